// File: rtl/delay_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : delay_bank_pkg                                             |
// | Description : Shared definitions for the delay bank: board-clock default |
// |               tick rate, channel FSM state encoding and the tick counter |
// |               width helper.                                              |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package delay_bank_pkg;

   // Board clock runs at 10 MHz, so one millisecond is 10000 cycles.
   localparam int DEFAULT_TICKS_PER_MS = 10000;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } chan_state_e;

   // Width needed to hold TICKS_PER_MS-1; never narrower than one bit so a
   // one-tick-per-ms configuration still has a legal counter.
   function automatic int tick_width(input int ticks);
      if (ticks <= 2) begin
         return 1;
      end
      return $clog2(ticks);
   endfunction

endpackage
`default_nettype wire

// File: rtl/delay_bank_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : delay_channel                                              |
// | Description : One independent millisecond delay channel. Two-state FSM   |
// |               (IDLE/RUN) with a sub-millisecond tick counter and a       |
// |               millisecond counter; one-shot or auto-reload operation.    |
// | Ports       : clk, rst        - clock, synchronous active-high reset     |
// |               set_i, cancel_i - start/restart and abort strobes          |
// |               periodic_i      - mode captured with set_i (1 = reload)    |
// |               ms_i            - duration in ms captured with set_i       |
// |               free_o          - 1 while the channel is idle (registered) |
// |               done_o          - one-cycle expiry pulse (registered)      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module delay_channel
   import delay_bank_pkg::*;
#(
   parameter int MS_WIDTH     = 8,
   parameter int TICKS_PER_MS = DEFAULT_TICKS_PER_MS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set_i,
   input  logic                cancel_i,
   input  logic                periodic_i,
   input  logic [MS_WIDTH-1:0] ms_i,
   output logic                free_o,
   output logic                done_o
);

   localparam int                    c_tick_w      = tick_width(TICKS_PER_MS);
   localparam logic [c_tick_w-1:0]   c_tick_reload = c_tick_w'(TICKS_PER_MS - 1);
   localparam logic [c_tick_w-1:0]   c_tick_zero   = '0;
   localparam logic [MS_WIDTH-1:0]   c_ms_one      = MS_WIDTH'(1);
   localparam logic [MS_WIDTH-1:0]   c_ms_zero     = '0;

   chan_state_e           state_q,  state_d;
   logic [c_tick_w-1:0]   tick_q,   tick_d;
   logic [MS_WIDTH-1:0]   ms_cnt_q, ms_cnt_d;
   logic [MS_WIDTH-1:0]   period_q, period_d;
   logic                  mode_q,   mode_d;
   logic                  done_q,   done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         tick_q   <= '0;
         ms_cnt_q <= '0;
         period_q <= '0;
         mode_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         ms_cnt_q <= ms_cnt_d;
         period_q <= period_d;
         mode_q   <= mode_d;
         done_q   <= done_d;
      end
   end

   // Priority: cancel > set > counting. Because set is evaluated before the
   // expiry test, a restart landing on the expiry edge suppresses that pulse.
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      ms_cnt_d = ms_cnt_q;
      period_d = period_q;
      mode_d   = mode_q;
      done_d   = 1'b0;

      if (cancel_i) begin
         state_d = ST_IDLE;
      end else if (set_i) begin
         if (ms_i == c_ms_zero) begin
            // A zero-length request is treated as an abort.
            state_d = ST_IDLE;
         end else begin
            state_d  = ST_RUN;
            tick_d   = c_tick_reload;
            ms_cnt_d = ms_i;
            period_d = ms_i;
            mode_d   = periodic_i;
         end
      end else if (state_q == ST_RUN) begin
         if (tick_q == c_tick_zero) begin
            if (ms_cnt_q == c_ms_one) begin
               done_d = 1'b1;
               if (mode_q) begin
                  ms_cnt_d = period_q;
                  tick_d   = c_tick_reload;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               ms_cnt_d = ms_cnt_q - c_ms_one;
               tick_d   = c_tick_reload;
            end
         end else begin
            tick_d = tick_q - c_tick_w'(1);
         end
      end
   end

   assign free_o = (state_q == ST_IDLE);
   assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/delay_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : delay_bank                                                 |
// | Description : Bank of CHANNELS independent millisecond delay timers.     |
// |               Each channel is a delay_channel instance fed with its own  |
// |               slice of the packed duration bus.                          |
// | Ports       : clk, rst  - clock, synchronous active-high reset           |
// |               set       - per-channel start/restart strobe               |
// |               cancel    - per-channel abort strobe                       |
// |               periodic  - per-channel mode (1 = auto-reload)             |
// |               ms        - packed durations, channel i at [i*MS_WIDTH+:]  |
// |               free      - per-channel idle flag                          |
// |               done      - per-channel one-cycle expiry pulse             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module delay_bank
   import delay_bank_pkg::*;
#(
   parameter int CHANNELS     = 4,
   parameter int MS_WIDTH     = 8,
   parameter int TICKS_PER_MS = DEFAULT_TICKS_PER_MS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CHANNELS-1:0]          set,
   input  logic [CHANNELS-1:0]          cancel,
   input  logic [CHANNELS-1:0]          periodic,
   input  logic [CHANNELS*MS_WIDTH-1:0] ms,
   output logic [CHANNELS-1:0]          free,
   output logic [CHANNELS-1:0]          done
);

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      delay_channel #(
         .MS_WIDTH     (MS_WIDTH),
         .TICKS_PER_MS (TICKS_PER_MS)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .set_i      (set[gi]),
         .cancel_i   (cancel[gi]),
         .periodic_i (periodic[gi]),
         .ms_i       (ms[gi*MS_WIDTH +: MS_WIDTH]),
         .free_o     (free[gi]),
         .done_o     (done[gi])
      );
   end

endmodule
`default_nettype wire

// File: doc/delay_bank.md
DELAY_BANK -- requirements
Module: delay_bank

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent delay channels (1..16).
REQ-002 Parameter MS_WIDTH, default 8, width of each channel's millisecond count.
REQ-003 Parameter TICKS_PER_MS, default 10000, clk cycles per millisecond (>=1).
REQ-004 Port clk  input  1  system clock; single clock domain.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port set  input  CHANNELS  per-channel start/restart strobe, sampled each clk edge.
REQ-007 Port cancel  input  CHANNELS  per-channel abort strobe.
REQ-008 Port periodic  input  CHANNELS  per-channel mode, sampled with set: 0 one-shot, 1 auto-reload.
REQ-009 Port ms  input  CHANNELS*MS_WIDTH  per-channel duration; channel i uses bits [i*MS_WIDTH +: MS_WIDTH].
REQ-010 Port free  output  CHANNELS  1 = channel idle.
REQ-011 Port done  output  CHANNELS  one-cycle expiry pulse.

Function
REQ-012 Each channel SHALL be a two-state FSM, IDLE/RUN; free[i] SHALL equal (state==IDLE), registered.
REQ-013 Per-channel priority SHALL be: rst > cancel > set > counting.
REQ-014 set[i] with ms_i=N>0 at edge k SHALL load period=N, ms_cnt=N, tick_cnt=TICKS_PER_MS-1, mode=periodic[i], enter RUN; free[i]=0 from cycle k+1.
REQ-015 In RUN, tick_cnt SHALL decrement each cycle; at tick_cnt==0 with ms_cnt>1, ms_cnt decrements and tick_cnt reloads TICKS_PER_MS-1.
REQ-016 Expiry (tick_cnt==0, ms_cnt==1) SHALL occur exactly N*TICKS_PER_MS cycles after the set edge; done[i]=1 for exactly that one following cycle.
REQ-017 One-shot expiry SHALL return to IDLE; free[i]=1 in the same cycle done[i]=1.
REQ-018 Periodic expiry SHALL reload ms_cnt=period and tick_cnt=TICKS_PER_MS-1, stay in RUN, free[i] stays 0; done pulses every N*TICKS_PER_MS cycles until cancel/rst.
REQ-019 set[i] while RUN SHALL restart with new ms/mode; no done for the aborted interval, even if expiry coincides with set.
REQ-020 set[i] with ms_i=0 SHALL act as cancel: IDLE, free=1, no done.
REQ-021 cancel[i] SHALL force IDLE next cycle, no done; cancel in IDLE has no effect.
REQ-022 Channels SHALL be fully independent; simultaneous events on different channels do not interact.
REQ-023 Counter widths: ms_cnt/period MS_WIDTH bits; tick_cnt max(1,$clog2(TICKS_PER_MS)) bits; no wrap-around; max duration (2^MS_WIDTH-1)*TICKS_PER_MS cycles.
REQ-024 TICKS_PER_MS=1 SHALL yield N-cycle delays with identical semantics.

Reset
REQ-025 rst SHALL, on the clk edge where high, force all channels IDLE, free=all ones, done=all zeros, counters and period zero.
REQ-026 rst mid-operation SHALL abort all channels without any done pulse; set/cancel during rst ignored.

Structure
REQ-027 A shared package SHALL hold default TICKS_PER_MS (10000 for the board clock), FSM state encoding (IDLE/RUN), and a tick-width helper function.
REQ-028 One sub-module, delay_channel, SHALL implement a single channel (FSM, counters, done/free); delay_bank SHALL instantiate CHANNELS copies via generate and slice ms.
REQ-029 No combinational path from inputs to free/done.

Verification (bench uses TICKS_PER_MS=4, MS_WIDTH=8, CHANNELS=4)
REQ-030 ch0 set, ms=3, periodic=0 -> free[0]=0 for 12 cycles; done[0] single pulse 12 cycles after set; free[0]=1 same cycle.
REQ-031 ch1 set, ms=2, periodic=1 -> done[1] at +8, +16, +24; free[1] stays 0; cancel at +20 -> free[1]=1 at +21, no pulse at +24.
REQ-032 ch2 set ms=5, re-set ms=1 at +10 -> done[2] only at +14 (4 cycles after re-set); no pulse at +20.
REQ-033 ch3 set ms=0 -> free[3] stays 1, no done; ms=255 -> done exactly 1020 cycles later.
REQ-034 All four channels running, rst pulsed 1 cycle -> all free=1 next cycle, no done pulses afterwards until new set.
REQ-035 set coincident with expiry cycle on ch0 (ms=2 reissued at +8 of ms=2 run) -> no done at +8, done at +16.
